vm_wb_ram_bridge: RTL

Parametrised successor to the PPU CPU-side memory bridge. Decodes VM2 Wishbone master cycles into direct RAM accesses (low address space and halt-mode space) and into NCH indirect-access channels (address register plus data port, each with optional auto-increment). RAM accesses are guarded by a response timeout. The block sits between `vm2_wb` and the shared 32-bit RAM port.

---
 rtl/vm_wb_pkg.sv | 26 ++
 rtl/vm_ich_regs.sv | 47 ++++
 rtl/vm_wb_ram_bridge.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vm_wb_pkg.sv
// vm_wb_pkg: shared types and default address map for the VM2 Wishbone to
// RAM bridge.
//   vm_state_e : bus-cycle FSM states
//   vm_dec_e   : address decode classes
//   RAM_TOP_DEF / IOBASE_DEF : default direct-RAM limit and channel base
package vm_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REG,
    ST_RAM,
    ST_DONE
  } vm_state_e;

  typedef enum logic [2:0] {
    DC_NONE,
    DC_DIRECT,
    DC_AREG,
    DC_DPORT,
    DC_CSR
  } vm_dec_e;

  localparam logic [15:0] RAM_TOP_DEF = 16'o160000;
  localparam logic [15:0] IOBASE_DEF  = 16'o176640;

endpackage

// File: rtl/vm_ich_regs.sv
// vm_ich_regs: indirect-channel register file.
//   areg_we/wr_ch/wr_sel/wr_dat : byte-lane write of one address register
//   csr_we                      : mode CSR write (low byte lane only)
//   inc_en/inc_ch               : completed data-port access, bumps areg when
//                                 that channel's auto-increment bit is set
//   areg/csr                    : current register contents
module vm_ich_regs
  import vm_wb_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int CH_W = 1
)(
  input  logic                  vm_clk_p,
  input  logic                  vm_init,
  input  logic                  areg_we,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [1:0]            wr_sel,
  input  logic [15:0]           wr_dat,
  input  logic                  csr_we,
  input  logic                  inc_en,
  input  logic [CH_W-1:0]       inc_ch,
  output logic [NCH-1:0][15:0]  areg,
  output logic [NCH-1:0]        csr
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [15:0] r;
    always_ff @(posedge vm_clk_p) begin
      if (vm_init) begin
        r <= '0;
      end else if (areg_we && wr_ch == CH_W'(k)) begin
        if (wr_sel[0]) r[7:0]  <= wr_dat[7:0];
        if (wr_sel[1]) r[15:8] <= wr_dat[15:8];
      end else if (inc_en && inc_ch == CH_W'(k) && csr[k]) begin
        r <= r + 16'd1;  // wraps FFFF -> 0
      end
    end
    assign areg[k] = r;
  end

  // All enable bits live in the low byte, so only sel[0] matters.
  always_ff @(posedge vm_clk_p) begin
    if (vm_init)                 csr <= '0;
    else if (csr_we && wr_sel[0]) csr <= wr_dat[NCH-1:0];
  end

endmodule

// File: rtl/vm_wb_ram_bridge.sv
// vm_wb_ram_bridge: decodes VM2 Wishbone cycles into direct RAM accesses,
// indirect channel register accesses and channel data-port RAM accesses.
//   vm_clk_p, vm_init     : clock, synchronous active-high reset
//   wbm_*                 : Wishbone slave side (adr[16] = halt-mode space)
//   addr_ram/duot_ram/dinp_ram/mask_ram/read_ram/wrte_ram/askn_ram : RAM port,
//                           data on bits [31:16], mask is active-high
//   tmo_o                 : one-cycle pulse when a RAM access times out
module vm_wb_ram_bridge
  import vm_wb_pkg::*;
#(
  parameter logic [15:0] RAM_TOP = RAM_TOP_DEF,
  parameter logic [15:0] IOBASE  = IOBASE_DEF,
  parameter int          NCH     = 2,
  parameter int          TMO     = 64
)(
  input  logic        vm_clk_p,
  input  logic        vm_init,
  input  logic [16:0] wbm_adr_i,
  input  logic [15:0] wbm_dat_i,
  output logic [15:0] wbm_dat_o,
  input  logic        wbm_we_i,
  input  logic [1:0]  wbm_sel_i,
  input  logic        wbm_stb_i,
  output logic        wbm_ack_o,
  output logic [15:0] addr_ram,
  output logic [31:0] duot_ram,
  input  logic [31:0] dinp_ram,
  output logic [3:0]  mask_ram,
  output logic        read_ram,
  output logic        wrte_ram,
  input  logic        askn_ram,
  output logic        tmo_o
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2(TMO);
  localparam logic [15:0] CSR_A = IOBASE + 16'(4 * NCH);

  vm_state_e            st, nxt;
  vm_dec_e              dec_cls;
  logic [CH_W-1:0]      dec_ch, cur_ch;
  logic                 cur_dport;
  logic [CNT_W-1:0]     tmo_cnt;
  logic                 reg_go, ram_go, ram_ok, ram_tmo;
  logic [15:0]          wadr, reg_rdata;
  logic [NCH-1:0][15:0] areg;
  logic [NCH-1:0]       csr;

  logic unused_ok;
  assign unused_ok = ^{dinp_ram[15:0], wbm_adr_i[0]};

  // Decode
  assign wadr = {wbm_adr_i[15:1], 1'b0};

  always_comb begin
    dec_cls = DC_NONE;
    dec_ch  = '0;
    if (wbm_adr_i[16] || wadr < RAM_TOP) begin
      dec_cls = DC_DIRECT;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wadr == IOBASE + 16'(4 * k)) begin
          dec_cls = DC_AREG;
          dec_ch  = CH_W'(k);
        end
        if (wadr == IOBASE + 16'(4 * k + 2)) begin
          dec_cls = DC_DPORT;
          dec_ch  = CH_W'(k);
        end
      end
      if (wadr == CSR_A) dec_cls = DC_CSR;
    end
  end

  assign reg_rdata = (dec_cls == DC_CSR) ? 16'(csr) : areg[dec_ch];

  // FSM
  always_ff @(posedge vm_clk_p) begin
    if (vm_init) st <= ST_IDLE;
    else         st <= nxt;
  end

  always_comb begin
    nxt     = st;
    reg_go  = 1'b0;
    ram_go  = 1'b0;
    ram_ok  = 1'b0;
    ram_tmo = 1'b0;
    if (!wbm_stb_i) begin
      nxt = ST_IDLE;  // abandoned cycle: nothing further is committed
    end else begin
      case (st)
        ST_IDLE: begin
          if (dec_cls == DC_AREG || dec_cls == DC_CSR) begin
            nxt    = ST_REG;
            reg_go = 1'b1;
          end else if (dec_cls == DC_DIRECT || dec_cls == DC_DPORT) begin
            nxt    = ST_RAM;
            ram_go = 1'b1;
          end
        end
        ST_REG:  nxt = ST_DONE;
        ST_RAM: begin
          if (askn_ram) begin
            nxt    = ST_DONE;
            ram_ok = 1'b1;
          end else if (tmo_cnt == CNT_W'(TMO - 1)) begin
            nxt     = ST_DONE;
            ram_tmo = 1'b1;
          end
        end
        ST_DONE: nxt = ST_DONE;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // RAM port
  assign read_ram = (st == ST_RAM) & ~wbm_we_i & wbm_stb_i;
  assign wrte_ram = (st == ST_RAM) &  wbm_we_i & wbm_stb_i;
  assign duot_ram = {wbm_dat_i, wbm_dat_i};
  assign mask_ram = {~wbm_sel_i, 2'b11};

  // Registered ack/data path; ack fires only on the transition into
  // REG/DONE, so it is a single-cycle pulse per strobe.
  always_ff @(posedge vm_clk_p) begin
    if (vm_init) begin
      wbm_ack_o <= 1'b0;
      wbm_dat_o <= '0;
      addr_ram  <= '0;
      tmo_o     <= 1'b0;
      tmo_cnt   <= '0;
      cur_dport <= 1'b0;
      cur_ch    <= '0;
    end else begin
      wbm_ack_o <= reg_go | ram_ok | ram_tmo;
      tmo_o     <= ram_tmo;
      if (reg_go)  wbm_dat_o <= wbm_we_i ? 16'h0 : reg_rdata;
      if (ram_ok)  wbm_dat_o <= wbm_we_i ? 16'h0 : dinp_ram[31:16];
      if (ram_tmo) wbm_dat_o <= 16'h0;
      if (ram_go) begin
        addr_ram  <= (dec_cls == DC_DPORT) ? areg[dec_ch] : {1'b0, wbm_adr_i[15:1]};
        cur_dport <= (dec_cls == DC_DPORT);
        cur_ch    <= dec_ch;
        tmo_cnt   <= '0;
      end else if (st == ST_RAM) begin
        tmo_cnt   <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  vm_ich_regs #(.NCH(NCH), .CH_W(CH_W)) u_ich (
    .vm_clk_p (vm_clk_p),
    .vm_init  (vm_init),
    .areg_we  (reg_go & wbm_we_i & (dec_cls == DC_AREG)),
    .wr_ch    (dec_ch),
    .wr_sel   (wbm_sel_i),
    .wr_dat   (wbm_dat_i),
    .csr_we   (reg_go & wbm_we_i & (dec_cls == DC_CSR)),
    .inc_en   (ram_ok & cur_dport),
    .inc_ch   (cur_ch),
    .areg     (areg),
    .csr      (csr)
  );

endmodule
